axi_mem_window_bridge: RTL and testbench
========================================

Name: axi_mem_window_bridge

Overview:
- Parametrised AXI4 bridge between the Rocket mem AXI master (s_ side) and the PS S_AXI DDR port (m_ side).
- Remaps a 2^WIN_BITS window onto WIN_BASE. Out-of-window requests are answered locally with DECERR instead of being aliased.
- Registers the AR and AW channels.
- Bounds outstanding bursts and preserves response ordering between forwarded and locally-errored bursts.

Parameters:
ADDR_W, 32, address width both sides
DATA_W, 64, data width (strb = DATA_W/8)
ID_W, 6, AXI ID width
WIN_BITS, 28, window size log2; in-window iff addr[ADDR_W-1:WIN_BITS]==0
WIN_BASE, 32'h1000_0000, m-side base; low WIN_BITS bits must be zero
MAX_OUT, 4, max forwarded bursts outstanding per direction (1..15)

Ports:
clock  in  1  sole clock
reset_n  in  1  async active-low reset
s_ar_valid/s_ar_bits in, s_ar_ready out  1/AX_W/1  AR from Rocket; AX_W = ADDR_W+ID_W+8+3+2 {addr,id,len,size,burst}
s_aw_valid/s_aw_bits in, s_aw_ready out  1/AX_W/1  AW from Rocket
s_w_valid/s_w_bits in, s_w_ready out  1/W_W/1  W_W = DATA_W+DATA_W/8+1 {data,strb,last}
s_b_valid/s_b_bits out, s_b_ready in  1/ID_W+2/1  {id,resp}
s_r_valid/s_r_bits out, s_r_ready in  1/R_W/1  R_W = ID_W+DATA_W+2+1 {id,data,resp,last}
m_ar_valid/m_ar_bits out, m_ar_ready in  mirror of s_ar toward PS
m_aw_valid/m_aw_bits out, m_aw_ready in  mirror of s_aw
m_w_valid/m_w_bits out, m_w_ready in  mirror of s_w
m_b_valid/m_b_bits in, m_b_ready out  mirror of s_b
m_r_valid/m_r_bits in, m_r_ready out  mirror of s_r
err_count  out  16  saturating count of DECERR bursts (read + write)

Behaviour:
- Reset (async assert, sync deassert by the integrator): all valid/ready outputs 0; slices empty; FSMs idle; rd_out, wr_out, err_count = 0. Reset mid-burst drops all state. No recovery of in-flight PS transactions.
- AR and AW each pass through a 2-entry skid slice. Throughput 1/cycle. s->m latency exactly 1 cycle. s_*_ready = slice not full.
- Remap: m_addr = WIN_BASE | addr[WIN_BITS-1:0]. id, len, size and burst are unchanged.
- Read path:
  - rd_out is incremented on m_ar handshake and decremented on m_r handshake with last. Simultaneous inc and dec leave it unchanged.
  - Slice head in-window: m_ar_valid when rd_out<MAX_OUT and the R FSM is R_IDLE.
  - Slice head out-of-window: popped when rd_out==0 and R_IDLE. R FSM loads id and beats=len and enters R_ERR.
  - In R_ERR: s_r = {id, data 0, resp 2'b11, last=(beats==0)}. Decrement beats on s_r handshake. After the last beat, return to R_IDLE and increment err_count.
  - While in R_ERR: m_r_ready=0. Otherwise m_r passes straight to s_r (combinational).
- Write FSM (W_IDLE, W_FWD, W_SINK, W_ERRB):
  - W_IDLE, s_w_ready=0:
    - In-window head, wr_out<MAX_OUT: m_aw_valid. On handshake -> W_FWD.
    - Out-of-window head: pop, latch id -> W_SINK.
  - W_FWD: s_w is wired to m_w. Handshake with last -> W_IDLE.
  - W_SINK: s_w_ready=1, data discarded. Beat with last -> W_ERRB.
  - W_ERRB:
    - Once wr_out==0: s_b = {id, 2'b11}, m_b_ready=0.
    - On s_b handshake: W_IDLE, err_count++.
  - Otherwise m_b passes to s_b.
  - wr_out is incremented on m_aw handshake and decremented on m_b handshake.
- Error responses wait for all forwarded bursts in the same direction to drain, which preserves same-ID ordering.
- err_count holds at 16'hFFFF.
- W beats never precede their AW through the bridge.
- At most one address-phase write occupies the W path at a time.

Decomposition:
- Package axi_win_pkg:
  - RESP_OKAY=2'b00, RESP_DECERR=2'b11.
  - Field-width localparams AX_W, W_W, R_W and field offsets for bit packing.
  - R FSM encoding (R_IDLE, R_ERR) and W FSM encoding (W_IDLE, W_FWD, W_SINK, W_ERRB).
- Sub-module axi_skid_slice (param WIDTH): 2-entry valid/ready register slice, instantiated for AR and AW.

Test Plan:
1. Forwarded read: AR addr 0x0000_1000, len 3, id 2 -> m_ar addr 0x1000_1000 exactly 1 cycle later. Four m_r beats reach s_r unchanged, last on beat 4. err_count 0.
2. Error read: AR addr 0x1000_0000, len 1, id 5 -> no m_ar. Two s_r beats {id 5, data 0, resp 11}, last on beat 2. err_count=1.
3. Error write: AW addr 0xF000_0000, len 0, id 3, one W beat with last -> m_aw_valid/m_w_valid never asserted. s_b {3, 11}. err_count=1.
4. Ordering: forwarded AR len 0 with m_r held off for 10 cycles, then error AR -> no error s_r beat until the forwarded beat handshakes. Then the error beat follows.
5. Backpressure: m_ar_ready=1, no R, 6 in-window ARs -> only 4 m_ar handshakes. s_ar_ready drops after the slice fills. 5th AR issues the cycle after the first R last.
6. Reset mid-burst: reset_n low during W_FWD beat 2 of 4 -> all valids 0 immediately. After release: rd_out, wr_out, err_count = 0 and a new AW is accepted.

Source files
------------

// File: rtl/axi_win_pkg.sv
// Shared field layout, response codes and FSM encodings for the DDR window bridge.
// Channel payloads are packed MSB-first in AXI field order.
package axi_win_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  // Address-channel packing {addr, id, len, size, burst}, LSB offsets
  localparam int AX_LEN_LSB = SIZE_W + BURST_W;
  localparam int AX_ID_LSB  = AX_LEN_LSB + LEN_W;

  function automatic int ax_width(input int addr_w, input int id_w);
    return addr_w + id_w + LEN_W + SIZE_W + BURST_W;
  endfunction

  function automatic int ax_addr_lsb(input int id_w);
    return AX_ID_LSB + id_w;
  endfunction

  function automatic int w_width(input int data_w);
    return data_w + data_w / 8 + 1;
  endfunction

  function automatic int b_width(input int id_w);
    return id_w + RESP_W;
  endfunction

  function automatic int r_width(input int id_w, input int data_w);
    return id_w + data_w + RESP_W + 1;
  endfunction

  // Widths at the default configuration (32-bit address, 64-bit data, 6-bit id)
  localparam int AX_W = ax_width(32, 6);
  localparam int W_W  = w_width(64);
  localparam int B_W  = b_width(6);
  localparam int R_W  = r_width(6, 64);

  typedef enum logic [0:0] {R_IDLE, R_ERR} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_SINK, W_ERRB} w_state_e;

endpackage

// File: rtl/axi_mem_window_bridge_if.sv
// Five-channel AXI4 bundle with packed payloads; master drives AR/AW/W, slave drives B/R.
interface axi_mem_window_bridge_if
  import axi_win_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 6
);

  logic                                 ar_valid;
  logic [ax_width(ADDR_W, ID_W)-1:0]    ar_bits;
  logic                                 ar_ready;
  logic                                 aw_valid;
  logic [ax_width(ADDR_W, ID_W)-1:0]    aw_bits;
  logic                                 aw_ready;
  logic                                 w_valid;
  logic [w_width(DATA_W)-1:0]           w_bits;
  logic                                 w_ready;
  logic                                 b_valid;
  logic [b_width(ID_W)-1:0]             b_bits;
  logic                                 b_ready;
  logic                                 r_valid;
  logic [r_width(ID_W, DATA_W)-1:0]     r_bits;
  logic                                 r_ready;

  modport master (
    output ar_valid, ar_bits, input  ar_ready,
    output aw_valid, aw_bits, input  aw_ready,
    output w_valid,  w_bits,  input  w_ready,
    input  b_valid,  b_bits,  output b_ready,
    input  r_valid,  r_bits,  output r_ready
  );

  modport slave (
    input  ar_valid, ar_bits, output ar_ready,
    input  aw_valid, aw_bits, output aw_ready,
    input  w_valid,  w_bits,  output w_ready,
    output b_valid,  b_bits,  input  b_ready,
    output r_valid,  r_bits,  input  r_ready
  );

endinterface

// File: rtl/axi_skid_slice.sv
// Two-entry valid/ready register slice: every output comes from a register,
// so input-to-output latency is one cycle and a full slice drops in_ready.
module axi_skid_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_bits,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bits,
  input  logic             out_ready
);

  logic [WIDTH-1:0] slot_p0 [2];
  logic [1:0]       cnt;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             live;
  logic             push;
  logic             pop;

  assign in_ready  = live && (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_bits  = slot_p0[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      live   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) slot_p0[wr_ptr] <= in_bits;
  end

endmodule

// File: rtl/axi_mem_window_bridge.sv
// AXI4 bridge from the Rocket mem port into a PS DDR window: remaps in-window
// addresses, answers out-of-window bursts locally with DECERR in response order.
module axi_mem_window_bridge
  import axi_win_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 64,
  parameter int              ID_W     = 6,
  parameter int              WIN_BITS = 28,
  parameter logic [ADDR_W-1:0] WIN_BASE = 32'h1000_0000,
  parameter int              MAX_OUT  = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  axi_mem_window_bridge_if.slave  s_axi,
  axi_mem_window_bridge_if.master m_axi,
  output logic [15:0]             err_count
);

  localparam int AX_BITS  = ax_width(ADDR_W, ID_W);
  localparam int ADDR_LSB = ax_addr_lsb(ID_W);
  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  function automatic logic in_win(input logic [AX_BITS-1:0] ax);
    return ax[AX_BITS-1:ADDR_LSB+WIN_BITS] == '0;
  endfunction

  function automatic logic [AX_BITS-1:0] remap(input logic [AX_BITS-1:0] ax);
    logic [ADDR_W-1:0]  a;
    logic [AX_BITS-1:0] r;
    a = ax[ADDR_LSB +: ADDR_W];
    a[ADDR_W-1:WIN_BITS] = '0;
    r = ax;
    r[ADDR_LSB +: ADDR_W] = WIN_BASE | a;
    return r;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic live;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) live <= 1'b0;
    else          live <= 1'b1;
  end

  // ---- Address slices (stage p0) ----
  logic               ar_hd_vld, ar_pop, aw_hd_vld, aw_pop;
  logic [AX_BITS-1:0] ar_hd_p0, aw_hd_p0;

  axi_skid_slice #(.WIDTH(AX_BITS)) u_ar_slice (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (s_axi.ar_valid),
    .in_bits   (s_axi.ar_bits),
    .in_ready  (s_axi.ar_ready),
    .out_valid (ar_hd_vld),
    .out_bits  (ar_hd_p0),
    .out_ready (ar_pop)
  );

  axi_skid_slice #(.WIDTH(AX_BITS)) u_aw_slice (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (s_axi.aw_valid),
    .in_bits   (s_axi.aw_bits),
    .in_ready  (s_axi.aw_ready),
    .out_valid (aw_hd_vld),
    .out_bits  (aw_hd_p0),
    .out_ready (aw_pop)
  );

  // ---- Read path ----
  r_state_e         r_state;
  logic [ID_W-1:0]  r_id;
  logic [LEN_W-1:0] r_beats;
  logic [3:0]       rd_out;
  logic             r_err, ar_err_pop, m_ar_hs, m_r_last_hs, s_r_hs, r_done;

  assign r_err      = (r_state == R_ERR);
  assign m_axi.ar_valid = ar_hd_vld && in_win(ar_hd_p0) && (rd_out < MAX_OUT_C) && (r_state == R_IDLE);
  assign m_axi.ar_bits  = remap(ar_hd_p0);
  // An error read may only answer once every forwarded read has returned
  assign ar_err_pop = ar_hd_vld && !in_win(ar_hd_p0) && (rd_out == 4'd0) && (r_state == R_IDLE);
  assign m_ar_hs    = m_axi.ar_valid && m_axi.ar_ready;
  assign ar_pop     = m_ar_hs || ar_err_pop;

  assign m_axi.r_ready = live && !r_err && s_axi.r_ready;
  assign s_axi.r_valid = r_err || (live && m_axi.r_valid);
  assign s_axi.r_bits  = r_err ? {r_id, {DATA_W{1'b0}}, RESP_DECERR, (r_beats == '0)} : m_axi.r_bits;
  assign m_r_last_hs   = m_axi.r_valid && m_axi.r_ready && m_axi.r_bits[0];
  assign s_r_hs        = s_axi.r_valid && s_axi.r_ready;
  assign r_done        = r_err && s_r_hs && (r_beats == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= R_IDLE;
      rd_out  <= 4'd0;
    end else begin
      unique case ({m_ar_hs, m_r_last_hs})
        2'b10:   rd_out <= rd_out + 4'd1;
        2'b01:   rd_out <= rd_out - 4'd1;
        default: rd_out <= rd_out;
      endcase
      case (r_state)
        R_IDLE: if (ar_err_pop) begin
          r_id    <= ar_hd_p0[AX_ID_LSB +: ID_W];
          r_beats <= ar_hd_p0[AX_LEN_LSB +: LEN_W];
          r_state <= R_ERR;
        end
        R_ERR: if (s_r_hs) begin
          if (r_beats == '0) r_state <= R_IDLE;
          else               r_beats <= r_beats - 1'b1;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---- Write path ----
  w_state_e        w_state;
  logic [ID_W-1:0] b_id;
  logic [3:0]      wr_out;
  logic            w_fwd, w_sink, b_err, aw_err_pop, m_aw_hs, m_b_hs, s_w_hs, s_b_hs, w_last, w_done;

  assign w_fwd      = (w_state == W_FWD);
  assign w_sink     = (w_state == W_SINK);
  assign m_axi.aw_valid = aw_hd_vld && in_win(aw_hd_p0) && (wr_out < MAX_OUT_C) && (w_state == W_IDLE);
  assign m_axi.aw_bits  = remap(aw_hd_p0);
  assign aw_err_pop = aw_hd_vld && !in_win(aw_hd_p0) && (w_state == W_IDLE);
  assign m_aw_hs    = m_axi.aw_valid && m_axi.aw_ready;
  assign aw_pop     = m_aw_hs || aw_err_pop;

  // W is only connected through while its own AW has already been issued
  assign m_axi.w_valid = w_fwd && s_axi.w_valid;
  assign m_axi.w_bits  = s_axi.w_bits;
  assign s_axi.w_ready = w_sink || (w_fwd && m_axi.w_ready);
  assign s_w_hs        = s_axi.w_valid && s_axi.w_ready;
  assign w_last        = s_axi.w_bits[0];

  assign b_err         = (w_state == W_ERRB) && (wr_out == 4'd0);
  assign s_axi.b_valid = b_err || (live && m_axi.b_valid);
  assign s_axi.b_bits  = b_err ? {b_id, RESP_DECERR} : m_axi.b_bits;
  assign m_axi.b_ready = live && !b_err && s_axi.b_ready;
  assign m_b_hs        = m_axi.b_valid && m_axi.b_ready;
  assign s_b_hs        = s_axi.b_valid && s_axi.b_ready;
  assign w_done        = b_err && s_b_hs;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_state <= W_IDLE;
      wr_out  <= 4'd0;
    end else begin
      unique case ({m_aw_hs, m_b_hs})
        2'b10:   wr_out <= wr_out + 4'd1;
        2'b01:   wr_out <= wr_out - 4'd1;
        default: wr_out <= wr_out;
      endcase
      case (w_state)
        W_IDLE:
          if (m_aw_hs) w_state <= W_FWD;
          else if (aw_err_pop) begin
            b_id    <= aw_hd_p0[AX_ID_LSB +: ID_W];
            w_state <= W_SINK;
          end
        W_FWD:  if (s_w_hs && w_last) w_state <= W_IDLE;
        W_SINK: if (s_w_hs && w_last) w_state <= W_ERRB;
        W_ERRB: if (w_done) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_count <= 16'd0;
    else if (r_done || w_done)
      err_count <= sat_add(err_count, {r_done && w_done, r_done ^ w_done});
  end

endmodule

// File: tb/tb_axi_mem_window_bridge.sv
// Directed scoreboard bench for axi_mem_window_bridge: drivers push expected
// channel payloads, negedge monitors pop and compare on every handshake.
module tb_axi_mem_window_bridge;
  import axi_win_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] err_count;

  always #5 clock = ~clock;

  axi_mem_window_bridge_if #(.ADDR_W(32), .DATA_W(64), .ID_W(6)) s_if ();
  axi_mem_window_bridge_if #(.ADDR_W(32), .DATA_W(64), .ID_W(6)) m_if ();

  axi_mem_window_bridge #(
    .ADDR_W(32), .DATA_W(64), .ID_W(6), .WIN_BITS(28),
    .WIN_BASE(32'h1000_0000), .MAX_OUT(4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .s_axi     (s_if.slave),
    .m_axi     (m_if.master),
    .err_count (err_count)
  );

  logic [AX_W-1:0] exp_mar[$];
  logic [AX_W-1:0] exp_maw[$];
  logic [W_W-1:0]  exp_mw[$];
  logic [R_W-1:0]  exp_sr[$];
  logic [B_W-1:0]  exp_sb[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int mar_cnt = 0;
  int mar_cyc = 0;
  int sr_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  task automatic unexpected(input string nm, input logic [127:0] act);
    checks++;
    $display("FAIL %s: got unexpected beat %0h, required none", nm, act);
  endtask

  function automatic logic [AX_W-1:0] ax(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
    return {a, id, len, 3'd3, 2'd1};
  endfunction

  function automatic logic [R_W-1:0] rx(input logic [5:0] id, input logic [63:0] d, input logic [1:0] resp, input logic last);
    return {id, d, resp, last};
  endfunction

  function automatic logic [W_W-1:0] wx(input logic [63:0] d, input logic [7:0] strb, input logic last);
    return {d, strb, last};
  endfunction

  // Monitors
  always @(negedge clock) begin
    if (m_if.ar_valid && m_if.ar_ready) begin
      mar_cnt++;
      mar_cyc = cyc;
      if (exp_mar.size() == 0) unexpected("m_ar", m_if.ar_bits);
      else chk("m_ar", m_if.ar_bits, exp_mar.pop_front());
    end
    if (m_if.aw_valid && m_if.aw_ready) begin
      if (exp_maw.size() == 0) unexpected("m_aw", m_if.aw_bits);
      else chk("m_aw", m_if.aw_bits, exp_maw.pop_front());
    end
    if (m_if.w_valid && m_if.w_ready) begin
      if (exp_mw.size() == 0) unexpected("m_w", m_if.w_bits);
      else chk("m_w", m_if.w_bits, exp_mw.pop_front());
    end
    if (s_if.r_valid && s_if.r_ready) begin
      sr_cyc = cyc;
      if (exp_sr.size() == 0) unexpected("s_r", s_if.r_bits);
      else chk("s_r", s_if.r_bits, exp_sr.pop_front());
    end
    if (s_if.b_valid && s_if.b_ready) begin
      if (exp_sb.size() == 0) unexpected("s_b", s_if.b_bits);
      else chk("s_b", s_if.b_bits, exp_sb.pop_front());
    end
  end

  task automatic timeout(input string nm);
    checks++;
    $display("FAIL %s timeout: no handshake in 200 cycles, required one", nm);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
    bit ok = 0;
    s_if.ar_bits = ax(a, id, len);
    s_if.ar_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock); ok = s_if.ar_ready;
      @(posedge clock); #1;
    end
    s_if.ar_valid = 1'b0;
    if (!ok) timeout("s_ar");
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
    bit ok = 0;
    s_if.aw_bits = ax(a, id, len);
    s_if.aw_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock); ok = s_if.aw_ready;
      @(posedge clock); #1;
    end
    s_if.aw_valid = 1'b0;
    if (!ok) timeout("s_aw");
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] strb, input logic last);
    bit ok = 0;
    s_if.w_bits = wx(d, strb, last);
    s_if.w_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock); ok = s_if.w_ready;
      @(posedge clock); #1;
    end
    s_if.w_valid = 1'b0;
    if (!ok) timeout("s_w");
  endtask

  task automatic r_beat(input logic [5:0] id, input logic [63:0] d, input logic [1:0] resp, input logic last);
    bit ok = 0;
    m_if.r_bits = rx(id, d, resp, last);
    m_if.r_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock); ok = m_if.r_ready;
      @(posedge clock); #1;
    end
    m_if.r_valid = 1'b0;
    if (!ok) timeout("m_r");
  endtask

  task automatic b_send(input logic [5:0] id, input logic [1:0] resp);
    bit ok = 0;
    m_if.b_bits = {id, resp};
    m_if.b_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock); ok = m_if.b_ready;
      @(posedge clock); #1;
    end
    m_if.b_valid = 1'b0;
    if (!ok) timeout("m_b");
  endtask

  function automatic logic [9:0] hs_outputs();
    return {s_if.ar_ready, s_if.aw_ready, s_if.w_ready, s_if.b_valid, s_if.r_valid,
            m_if.ar_valid, m_if.aw_valid, m_if.w_valid, m_if.b_ready, m_if.r_ready};
  endfunction

  function automatic int pending();
    return exp_mar.size() + exp_maw.size() + exp_mw.size() + exp_sr.size() + exp_sb.size();
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int t0;
    s_if.ar_valid = 0; s_if.ar_bits = '0; s_if.aw_valid = 0; s_if.aw_bits = '0;
    s_if.w_valid = 0;  s_if.w_bits = '0;  s_if.b_ready = 1;  s_if.r_ready = 1;
    m_if.ar_ready = 1; m_if.aw_ready = 1; m_if.w_ready = 1;
    m_if.b_valid = 0;  m_if.b_bits = '0;  m_if.r_valid = 0;  m_if.r_bits = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset outputs", hs_outputs(), 0);
    chk("reset err_count", err_count, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(2);

    // 1: forwarded read, remap and 1-cycle latency
    exp_mar.push_back(ax(32'h1000_1000, 6'd2, 8'd3));
    t0 = cyc;
    ar_send(32'h0000_1000, 6'd2, 8'd3);
    idle(3);
    chk("t1 m_ar latency", mar_cyc - t0, 1);
    for (int k = 0; k < 4; k++) begin
      exp_sr.push_back(rx(6'd2, 64'hA0 + k, RESP_OKAY, k == 3));
      r_beat(6'd2, 64'hA0 + k, RESP_OKAY, k == 3);
    end
    idle(2);
    chk("t1 err_count", err_count, 0);
    chk("t1 drained", pending(), 0);

    // 2: out-of-window read answered locally
    exp_sr.push_back(rx(6'd5, 64'd0, RESP_DECERR, 1'b0));
    exp_sr.push_back(rx(6'd5, 64'd0, RESP_DECERR, 1'b1));
    ar_send(32'h1000_0000, 6'd5, 8'd1);
    idle(8);
    chk("t2 err_count", err_count, 1);
    chk("t2 drained", pending(), 0);

    // 3: out-of-window write sunk, then a forwarded write with B passthrough
    exp_sb.push_back({6'd3, RESP_DECERR});
    aw_send(32'hF000_0000, 6'd3, 8'd0);
    w_send(64'hDEAD, 8'hFF, 1'b1);
    idle(6);
    chk("t3 err_count", err_count, 2);
    exp_maw.push_back(ax(32'h1000_0040, 6'd9, 8'd1));
    exp_mw.push_back(wx(64'h11, 8'hFF, 1'b0));
    exp_mw.push_back(wx(64'h22, 8'h0F, 1'b1));
    exp_sb.push_back({6'd9, RESP_OKAY});
    aw_send(32'h0000_0040, 6'd9, 8'd1);
    w_send(64'h11, 8'hFF, 1'b0);
    w_send(64'h22, 8'h0F, 1'b1);
    b_send(6'd9, RESP_OKAY);
    idle(3);
    chk("t3 drained", pending(), 0);

    // 4: error read waits behind an outstanding forwarded read
    exp_mar.push_back(ax(32'h1000_0020, 6'd1, 8'd0));
    ar_send(32'h0000_0020, 6'd1, 8'd0);
    ar_send(32'h8000_0000, 6'd1, 8'd0);
    idle(10);
    chk("t4 s_r held", s_if.r_valid, 0);
    exp_sr.push_back(rx(6'd1, 64'h55, RESP_OKAY, 1'b1));
    exp_sr.push_back(rx(6'd1, 64'd0, RESP_DECERR, 1'b1));
    r_beat(6'd1, 64'h55, RESP_OKAY, 1'b1);
    idle(5);
    chk("t4 err_count", err_count, 3);
    chk("t4 drained", pending(), 0);

    // 5: outstanding-read limit and slice backpressure
    mar_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      exp_mar.push_back(ax(32'h1000_0100 + 32'(i * 64), 6'(i), 8'd0));
      ar_send(32'h0000_0100 + 32'(i * 64), 6'(i), 8'd0);
    end
    idle(3);
    chk("t5 m_ar count", mar_cnt, 4);
    chk("t5 s_ar_ready", s_if.ar_ready, 0);
    exp_sr.push_back(rx(6'd0, 64'h500, RESP_OKAY, 1'b1));
    r_beat(6'd0, 64'h500, RESP_OKAY, 1'b1);
    idle(2);
    chk("t5 reissue latency", mar_cyc - sr_cyc, 1);
    chk("t5 m_ar count after R", mar_cnt, 5);
    for (int i = 1; i < 6; i++) begin
      exp_sr.push_back(rx(6'(i), 64'h500 + 64'(i), RESP_OKAY, 1'b1));
      r_beat(6'(i), 64'h500 + 64'(i), RESP_OKAY, 1'b1);
    end
    idle(3);
    chk("t5 drained", pending(), 0);

    // 6: reset in the middle of a forwarded write burst with a read outstanding
    exp_mar.push_back(ax(32'h1000_0300, 6'd6, 8'd0));
    ar_send(32'h0000_0300, 6'd6, 8'd0);
    exp_maw.push_back(ax(32'h1000_0400, 6'd4, 8'd3));
    aw_send(32'h0000_0400, 6'd4, 8'd3);
    exp_mw.push_back(wx(64'h1, 8'hFF, 1'b0));
    w_send(64'h1, 8'hFF, 1'b0);
    m_if.w_ready = 1'b0;
    s_if.w_bits = wx(64'h2, 8'hFF, 1'b0);
    s_if.w_valid = 1'b1;
    idle(2);
    chk("t6 m_w_valid before reset", m_if.w_valid, 1);
    #2 reset_n = 1'b0;
    #1 chk("t6 outputs in reset", hs_outputs(), 0);
    s_if.w_valid = 1'b0;
    m_if.w_ready = 1'b1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(2);
    chk("t6 err_count", err_count, 0);
    exp_sr.push_back(rx(6'd2, 64'd0, RESP_DECERR, 1'b1));
    ar_send(32'h4000_0000, 6'd2, 8'd0);
    idle(5);
    exp_sb.push_back({6'd1, RESP_DECERR});
    aw_send(32'h2000_0000, 6'd1, 8'd0);
    w_send(64'h0, 8'h00, 1'b1);
    idle(5);
    exp_maw.push_back(ax(32'h1FFF_FFF0, 6'd7, 8'd0));
    exp_mw.push_back(wx(64'h77, 8'h0F, 1'b1));
    exp_sb.push_back({6'd7, RESP_OKAY});
    aw_send(32'h0FFF_FFF0, 6'd7, 8'd0);
    w_send(64'h77, 8'h0F, 1'b1);
    b_send(6'd7, RESP_OKAY);
    idle(4);
    chk("t6 err_count after", err_count, 2);
    chk("t6 drained", pending(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
